clk_ratio_monitor: RTL and testbench

CLK_RATIO_MONITOR -- requirements
Module: clk_ratio_monitor

---
 rtl/clk_ratio_monitor.sv | 233 +++++++++++++++++++++++
 tb/tb_clk_ratio_monitor.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_ratio_monitor.sv
// clk_ratio_monitor
// Measures the period of a divided clock (i_mon_clk) in cycles of i_ref_clk.
// i_mon_clk is treated as asynchronous data: it is synchronized, then
// edge-detected, and an FSM counts high and low phase lengths. Each complete
// period publishes o_ratio with a one-cycle o_valid pulse. o_locked reports
// LOCK_COUNT consecutive identical measurements. o_timeout reports a missing
// or too-slow monitored clock.
//
// Optional build macro: CLK_RATIO_MONITOR_DUTY_EN
//   When defined, the high-phase length is published on o_high_cnt, and lock
//   also requires the high phase to match the previous measurement.
//
// Debug: o_dbg_state exposes the FSM state encoding (IDLE=0, WAIT_RISE=1,
// MEAS_HIGH=2, MEAS_LOW=3).
module clk_ratio_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic       i_ref_clk,
  input  logic       i_rst,
  input  logic       i_mon_clk,
  input  logic       i_enable,
  output logic [7:0] o_ratio,
  output logic       o_valid,
  output logic       o_locked,
  output logic       o_timeout,
  output logic [1:0] o_dbg_state
`ifdef CLK_RATIO_MONITOR_DUTY_EN
  ,
  output logic [7:0] o_high_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_RISE = 2'd1,
    S_MEAS_HIGH = 2'd2,
    S_MEAS_LOW  = 2'd3
  } state_t;

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

  state_t                 r_state;
  state_t                 w_state_next;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_prev;
  logic                   w_s;
  logic                   w_rise;
  logic                   w_fall;

  logic [7:0]             r_high_cnt;
  logic [7:0]             r_low_cnt;
  logic [3:0]             r_match_cnt;
  logic [7:0]             r_ratio;
  logic                   r_valid;
  logic                   r_locked;
  logic                   r_timeout;
`ifdef CLK_RATIO_MONITOR_DUTY_EN
  logic [7:0]             r_high_pub;
`endif

  logic [8:0]             w_sum;
  logic                   w_sum_ovf;
  logic                   w_same;
  logic [3:0]             w_match_next;

  // Strobes from the FSM output decoder to the datapath
  logic                   w_clear;
  logic                   w_load_high;
  logic                   w_inc_high;
  logic                   w_load_low;
  logic                   w_inc_low;
  logic                   w_done;
  logic                   w_tmo;

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_rise    = w_s & ~r_s_prev;
  assign w_fall    = ~w_s & r_s_prev;
  assign w_sum     = {1'b0, r_high_cnt} + {1'b0, r_low_cnt};
  assign w_sum_ovf = (w_sum > 9'd255);

`ifdef CLK_RATIO_MONITOR_DUTY_EN
  assign w_same = (w_sum[7:0] == r_ratio) && (r_high_cnt == r_high_pub);
`else
  assign w_same = (w_sum[7:0] == r_ratio);
`endif

  // Match count after a valid measurement: restart at 1 on change, else saturate
  always_comb begin
    w_match_next = 4'd1;
    if (w_same) begin
      if (r_match_cnt >= LOCK_CNT) w_match_next = LOCK_CNT;
      else                         w_match_next = r_match_cnt + 4'd1;
    end
  end

  // Synchronizer chain and edge-detect history flop
  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync   <= '0;
      r_s_prev <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], i_mon_clk};
      r_s_prev <= w_s;
    end
  end

  // FSM state register
  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next-state logic; disable always wins, counters at 255 abort to WAIT_RISE
  always_comb begin
    w_state_next = r_state;
    if (!i_enable) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:      w_state_next = S_WAIT_RISE;
        S_WAIT_RISE: if (w_rise) w_state_next = S_MEAS_HIGH;
        S_MEAS_HIGH: begin
          if (r_high_cnt == 8'd255) w_state_next = S_WAIT_RISE;
          else if (w_fall)          w_state_next = S_MEAS_LOW;
        end
        S_MEAS_LOW: begin
          if (r_low_cnt == 8'd255) w_state_next = S_WAIT_RISE;
          else if (w_rise)         w_state_next = w_sum_ovf ? S_WAIT_RISE : S_MEAS_HIGH;
        end
        default:     w_state_next = S_IDLE;
      endcase
    end
  end

  // FSM output decode: datapath strobes for the current state and edges
  always_comb begin
    w_clear     = 1'b0;
    w_load_high = 1'b0;
    w_inc_high  = 1'b0;
    w_load_low  = 1'b0;
    w_inc_low   = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    if (!i_enable) begin
      w_clear = 1'b1;
    end else begin
      case (r_state)
        S_WAIT_RISE: if (w_rise) w_load_high = 1'b1;
        S_MEAS_HIGH: begin
          if (r_high_cnt == 8'd255) w_tmo      = 1'b1;
          else if (w_fall)          w_load_low = 1'b1;
          else                      w_inc_high = 1'b1;
        end
        S_MEAS_LOW: begin
          if (r_low_cnt == 8'd255) begin
            w_tmo = 1'b1;
          end else if (w_rise) begin
            if (w_sum_ovf) begin
              w_tmo = 1'b1;
            end else begin
              w_done      = 1'b1;
              w_load_high = 1'b1;
            end
          end else begin
            w_inc_low = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath: phase counters, published ratio, lock tracking, timeout flag
  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      r_high_cnt  <= 8'd0;
      r_low_cnt   <= 8'd0;
      r_match_cnt <= 4'd0;
      r_ratio     <= 8'd0;
      r_valid     <= 1'b0;
      r_locked    <= 1'b0;
      r_timeout   <= 1'b0;
`ifdef CLK_RATIO_MONITOR_DUTY_EN
      r_high_pub  <= 8'd0;
`endif
    end else begin
      r_valid <= 1'b0;
      if (w_clear) begin
        r_high_cnt  <= 8'd0;
        r_low_cnt   <= 8'd0;
        r_match_cnt <= 4'd0;
        r_locked    <= 1'b0;
      end else begin
        if (w_load_high)     r_high_cnt <= 8'd1;
        else if (w_inc_high) r_high_cnt <= (r_high_cnt == 8'd255) ? 8'd255 : r_high_cnt + 8'd1;

        if (w_load_low)      r_low_cnt <= 8'd1;
        else if (w_inc_low)  r_low_cnt <= (r_low_cnt == 8'd255) ? 8'd255 : r_low_cnt + 8'd1;

        if (w_tmo) begin
          r_timeout   <= 1'b1;
          r_locked    <= 1'b0;
          r_match_cnt <= 4'd0;
          r_high_cnt  <= 8'd0;
          r_low_cnt   <= 8'd0;
        end

        if (w_done) begin
          r_ratio     <= w_sum[7:0];
          r_valid     <= 1'b1;
          r_timeout   <= 1'b0;
          r_match_cnt <= w_match_next;
          r_locked    <= (w_match_next == LOCK_CNT);
`ifdef CLK_RATIO_MONITOR_DUTY_EN
          r_high_pub  <= r_high_cnt;
`endif
        end
      end
    end
  end

  assign o_ratio     = r_ratio;
  assign o_valid     = r_valid;
  assign o_locked    = r_locked;
  assign o_timeout   = r_timeout;
  assign o_dbg_state = r_state;
`ifdef CLK_RATIO_MONITOR_DUTY_EN
  assign o_high_cnt  = r_high_pub;
`endif

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Bench for clk_ratio_monitor. i_mon_clk is driven as a sequence of
// (high, low) phase lengths in ref cycles. A period-level model turns each
// phase pair into an expected measurement (or a timeout / skipped period)
// and queues it; a monitor pops on every o_valid and compares.
module tb_clk_ratio_monitor;
  localparam int SYNC_STAGES = 2;
  localparam int LOCK_COUNT  = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       mon;
  logic       en;
  logic [7:0] o_ratio;
  logic       o_valid;
  logic       o_locked;
  logic       o_timeout;
  logic [1:0] o_dbg_state;
`ifdef CLK_RATIO_MONITOR_DUTY_EN
  logic [7:0] o_high_cnt;
`endif

  always #5 clk = ~clk;

  clk_ratio_monitor #(
    .SYNC_STAGES(SYNC_STAGES),
    .LOCK_COUNT (LOCK_COUNT)
  ) dut (
    .i_ref_clk  (clk),
    .i_rst      (rst),
    .i_mon_clk  (mon),
    .i_enable   (en),
    .o_ratio    (o_ratio),
    .o_valid    (o_valid),
    .o_locked   (o_locked),
    .o_timeout  (o_timeout),
    .o_dbg_state(o_dbg_state)
`ifdef CLK_RATIO_MONITOR_DUTY_EN
    ,
    .o_high_cnt (o_high_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  // {high[7:0], locked, ratio[7:0]}
  logic [16:0] exp_q[$];

  // Period-level reference state
  int m_prev_ratio = 0;
  int m_prev_high  = 0;
  int m_match      = 0;
  bit m_skip       = 0;
  bit m_tmo        = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One full monitored period of h high + l low cycles, measured from its rise.
  function automatic void model_period(input int h, input int l);
    bit same;
    if (m_skip) begin
      // The rise that ended an over-long period only re-arms the measurement
      m_skip = 0;
      return;
    end
    if (h + l > 255) begin
      m_match = 0;
      m_tmo   = 1;
      // If neither phase alone hit 255, the overflow is seen at the closing
      // rise, and the period starting there is discarded.
      if (h < 255 && l < 255) m_skip = 1;
      return;
    end
`ifdef CLK_RATIO_MONITOR_DUTY_EN
    same = (h + l == m_prev_ratio) && (h == m_prev_high);
`else
    same = (h + l == m_prev_ratio);
`endif
    if (same) m_match = (m_match + 1 > LOCK_COUNT) ? LOCK_COUNT : m_match + 1;
    else      m_match = 1;
    m_prev_ratio = h + l;
    m_prev_high  = h;
    m_tmo        = 0;
    exp_q.push_back({8'(h), (m_match == LOCK_COUNT), 8'(h + l)});
  endfunction

  function automatic void model_disable();
    m_match = 0;
    m_skip  = 0;
  endfunction

  function automatic void model_reset();
    m_prev_ratio = 0;
    m_prev_high  = 0;
    m_match      = 0;
    m_skip       = 0;
    m_tmo        = 0;
  endfunction

  // Monitor: compare every published measurement against the queue head
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (!rst && o_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: got ratio %0d expected no valid at %0t", o_ratio, $time);
        end else begin
          e = exp_q.pop_front();
          check("ratio", o_ratio, e[7:0]);
          check("locked_at_valid", o_locked, e[8]);
          check("timeout_at_valid", o_timeout, 0);
`ifdef CLK_RATIO_MONITOR_DUTY_EN
          check("high_cnt", o_high_cnt, e[16:9]);
`endif
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_high(input int n);
    mon = 1'b1;
    tick(n);
  endtask

  task automatic drive_low(input int n);
    mon = 1'b0;
    tick(n);
  endtask

  task automatic period(input int h, input int l);
    model_period(h, l);
    drive_high(h);
    drive_low(l);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      tick(1);
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    en  = 1'b0;
    mon = 1'b0;
    tick(5);
    rst = 1'b0;
    tick(1);
    check("reset_ratio", o_ratio, 0);
    check("reset_valid", o_valid, 0);
    check("reset_locked", o_locked, 0);
    check("reset_timeout", o_timeout, 0);

    // Enable with the monitored clock low so measurement starts at a clean rise
    en = 1'b1;
    drive_low(6);

    // ref/4 then ref/7: lock on the 4th identical measurement
    for (int i = 0; i < 6; i++) period(2, 2);
    for (int i = 0; i < 5; i++) period(3, 4);

    // Locked at 4, switch to 6: lock drops on the first 6, returns on the 4th
    for (int i = 0; i < 5; i++) period(2, 2);
    for (int i = 0; i < 5; i++) period(3, 3);

    // Stuck high after a rise -> timeout, then recovery at ref/4
    period(2, 2);
    model_period(300, 2);
    drive_high(300);
    check("timeout_stuck_high", o_timeout, 1);
    check("locked_stuck_high", o_locked, 0);
    drive_low(2);
    for (int i = 0; i < 5; i++) period(2, 2);

    // Period longer than 255 with both phases short enough: overflow at the rise
    period(200, 100);
    period(2, 2);
    check("timeout_sum_overflow", o_timeout, 1);
    for (int i = 0; i < 5; i++) period(2, 2);

    // Randomized runs of repeated periods
    for (int g = 0; g < 12; g++) begin
      int h;
      int l;
      int reps;
      h    = $urandom_range(1, 12);
      l    = $urandom_range(1, 12);
      reps = $urandom_range(1, 6);
      for (int r = 0; r < reps; r++) period(h, l);
    end

    // Disable exactly in the completion cycle of a period
    for (int i = 0; i < 4; i++) period(2, 2);
    model_disable();
    drive_high(2);
    drive_low(2);
    mon = 1'b1;
    repeat (SYNC_STAGES) @(posedge clk);
    #1;
    en = 1'b0;
    tick(3);
    check("disable_locked", o_locked, 0);
    check("disable_valid", o_valid, 0);
    check("disable_ratio_hold", o_ratio, m_prev_ratio);
    mon = 1'b0;
    tick(3);
    en = 1'b1;
    drive_low(6);

    // Reset in the middle of the low phase of a ratio-8 clock
    for (int i = 0; i < 3; i++) period(4, 4);
    drive_high(4);
    drive_low(2);
    #2;
    rst = 1'b1;
    #1;
    check("midreset_ratio", o_ratio, 0);
    check("midreset_valid", o_valid, 0);
    check("midreset_locked", o_locked, 0);
    check("midreset_timeout", o_timeout, 0);
    check("midreset_queue_empty", exp_q.size(), 0);
    model_reset();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive_low(2);
    for (int i = 0; i < 5; i++) period(4, 4);

    // Close the last period and let the queue empty
    drive_high(2);
    drive_low(2);
    drain("final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
